// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, issues one fetch at a time and buffers the word for decode
module pc_fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d, if_pc_d;
    logic [31:0]     if_instr_d, fetch_count_d;
    logic            misalign_d, redir, misaligned, capture, xfer;

    assign imem_req_valid = state == REQ;
    assign imem_req_addr  = pc;
    assign if_valid       = state == HOLD;

    // Next state and datapath: redirects outrank everything except the IDLE start-up cycle
    always_comb begin
        redir         = redirect_valid && state != IDLE;
        misaligned    = redirect_target[1:0] != 2'b00;
        capture       = state == WAIT && imem_rsp_valid && !redir;
        xfer          = state == HOLD && if_ready;
        misalign_d    = redir && misaligned;
        if_instr_d    = capture ? imem_rsp_data : if_instr;
        if_pc_d       = capture ? pc : if_pc;
        fetch_count_d = xfer ? fetch_count + 32'd1 : fetch_count;
        pc_d          = redir ? (misaligned ? TRAP_VEC : redirect_target) :
                        xfer  ? pc + XLEN'(4) : pc;
        state_d       = state;
        case (state)
            IDLE:    state_d = REQ;
            REQ:     state_d = imem_req_ready ? (redir ? DROP : WAIT) : REQ;
            WAIT:    state_d = imem_rsp_valid ? (redir ? REQ : HOLD) : (redir ? DROP : WAIT);
            HOLD:    state_d = (redir || if_ready) ? REQ : HOLD;
            DROP:    state_d = (imem_rsp_valid && !redir) ? REQ : DROP;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            if_instr     <= '0;
            if_pc        <= '0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            if_instr     <= if_instr_d;
            if_pc        <= if_pc_d;
            misalign_err <= misalign_d;
            fetch_count  <= fetch_count_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: randomized memory/decode/execute stimulus against a transaction-level PC model
module tb_pc_fetch_sequencer;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk = 1'b0, rst = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        if_valid, if_ready = 1'b0;
    logic [31:0] if_instr, if_pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    pc_fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t       exp_q[$];
    int          checks = 0, failures = 0;
    int          mon_count, transfers = 0, delay;
    logic [31:0] exp_pc, out_addr, out_data;
    bit          outstanding, live, buffered, exp_mis, pend_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc      = 32'h0;
        outstanding = 0;
        live        = 0;
        buffered    = 0;
        exp_mis     = 0;
        pend_mis    = 0;
        mon_count   = 0;
        delay       = 0;
    endtask

    // Called just after a rising edge: asserts reset, checks reset values, releases, returns after the IDLE edge
    task automatic do_reset();
        rst = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; redirect_valid = 0; if_ready = 0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_fetch_count", fetch_count, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        model_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // One cycle of stimulus plus the model's view of what that rising edge does
    task automatic step(input bit directed);
        bit          rdy, rsp, ifr, rd, xfer;
        logic [31:0] tgt;
        exp_mis = pend_mis;
        chk("if_valid_vs_buffered", if_valid, buffered);
        if (imem_req_valid) chk("single_outstanding", outstanding | buffered, 0);
        rdy = directed ? 1'b1 : ($urandom_range(0, 9) < 7);
        rsp = outstanding && delay == 0;
        ifr = directed ? 1'b1 : ($urandom_range(0, 9) < 6);
        rd  = !directed && $urandom_range(0, 99) < 8 && !(rsp && !live);
        tgt = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
        imem_req_ready  = rdy;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = rsp ? out_data : $urandom;
        if_ready        = ifr;
        redirect_valid  = rd;
        redirect_target = rd ? tgt : $urandom;
        xfer = buffered && ifr;
        if (buffered && !ifr && rd) begin
            void'(exp_q.pop_back());
            buffered = 0;
        end
        if (xfer) begin
            buffered = 0;
            transfers++;
        end
        if (rsp) begin
            outstanding = 0;
            if (live && !rd) begin
                exp_q.push_back('{out_addr, out_data});
                buffered = 1;
            end
        end else if (outstanding) begin
            if (rd) live = 0;
            delay--;
        end
        if (imem_req_valid && rdy) begin
            chk("req_addr", imem_req_addr, exp_pc);
            outstanding = 1;
            live        = !rd;
            out_addr    = exp_pc;
            out_data    = $urandom;
            delay       = directed ? 0 : $urandom_range(0, 2);
        end
        exp_pc   = rd ? (tgt[1:0] != 2'b00 ? TRAP : tgt) : xfer ? exp_pc + 32'd4 : exp_pc;
        pend_mis = rd && tgt[1:0] != 2'b00;
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every decode handshake and tracks counter/error outputs
    always @(negedge clk) begin
        item_t e;
        if (rst) begin
            chk("fetch_count", fetch_count, 32'(mon_count));
            chk("misalign_err", misalign_err, exp_mis);
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transfer if_pc=%h if_instr=%h", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                end
                mon_count++;
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        do_reset();
        repeat (20) step(1);
        repeat (1500) step(0);
        for (int i = 0; i < 50 && !buffered; i++) step(0);
        do_reset();
        repeat (10) step(1);
        repeat (1500) step(0);
        chk("progress", 32'(transfers > 100), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
